branch_resolve_checker: RTL

- Sits directly downstream of the 2-bit saturating branch predictor and consumes its `prediction` output.
- Buffers in-flight predictions in program order in a small FIFO.
- When each branch resolves, compares the oldest buffered prediction with the actual outcome.
- On a miss, raises a one-cycle flush pulse, discards wrong-path predictions and updates accuracy statistics.

---
 rtl/branch_resolve_checker.sv | 115 +++++++++++
 1 files changed

// File: rtl/branch_resolve_checker.sv
// Buffers in-flight branch predictions in program order and checks each one
// against the resolved outcome, flushing wrong-path entries on a miss.
module branch_resolve_checker #(
   parameter int DEPTH = 4,
   parameter int CNT_W = 16
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     pred_valid,
   input  logic                     pred_bit,
   input  logic                     resolve_valid,
   input  logic                     resolve_taken,
   input  logic                     clear_stats,
   output logic                     mispredict,
   output logic                     resolved_pred,
   output logic [$clog2(DEPTH):0]   occupancy,
   output logic                     full,
   output logic                     empty,
   output logic [CNT_W-1:0]         branch_cnt,
   output logic [CNT_W-1:0]         mispredict_cnt,
   output logic                     overflow_err,
   output logic                     underflow_err
);

   localparam int AW = $clog2(DEPTH);
   localparam logic [AW:0] DEPTH_OCC = (AW+1)'(DEPTH);

   logic [DEPTH-1:0] entries;
   logic [AW-1:0]    rd_ptr;
   logic [AW-1:0]    wr_ptr;

   logic head;
   logic pop;
   logic miss;
   logic push;
   logic overflow;
   logic underflow;

   assign empty     = (occupancy == '0);
   assign full      = (occupancy == DEPTH_OCC);
   assign head      = entries[rd_ptr];
   assign pop       = resolve_valid && !empty;
   assign miss      = pop && (head ^ resolve_taken);
   // A full buffer only accepts a push when a correct pop frees a slot; a
   // push alongside a miss is wrong-path and vanishes without an error.
   assign push      = pred_valid && !miss && (!full || pop);
   assign overflow  = pred_valid && full && !pop;
   assign underflow = resolve_valid && empty;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         entries   <= '0;
         rd_ptr    <= '0;
         wr_ptr    <= '0;
         occupancy <= '0;
      end else if (miss) begin
         rd_ptr    <= '0;
         wr_ptr    <= '0;
         occupancy <= '0;
      end else begin
         if (push) begin
            entries[wr_ptr] <= pred_bit;
            wr_ptr          <= wr_ptr + 1'b1;
         end
         if (pop) begin
            rd_ptr <= rd_ptr + 1'b1;
         end
         case ({push, pop})
            2'b10:   occupancy <= occupancy + 1'b1;
            2'b01:   occupancy <= occupancy - 1'b1;
            default: occupancy <= occupancy;
         endcase
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         mispredict    <= 1'b0;
         resolved_pred <= 1'b0;
      end else begin
         mispredict <= miss;
         if (pop) begin
            resolved_pred <= head;
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         branch_cnt     <= '0;
         mispredict_cnt <= '0;
         overflow_err   <= 1'b0;
         underflow_err  <= 1'b0;
      end else if (clear_stats) begin
         branch_cnt     <= '0;
         mispredict_cnt <= '0;
         overflow_err   <= 1'b0;
         underflow_err  <= 1'b0;
      end else begin
         if (pop && (branch_cnt != '1)) begin
            branch_cnt <= branch_cnt + 1'b1;
         end
         if (miss && (mispredict_cnt != '1)) begin
            mispredict_cnt <= mispredict_cnt + 1'b1;
         end
         if (overflow) begin
            overflow_err <= 1'b1;
         end
         if (underflow) begin
            underflow_err <= 1'b1;
         end
      end
   end

endmodule
